iiitb_usr_ctrl: RTL and testbench
=================================

// Module: iiitb_usr_ctrl
// PURPOSE
//  Command sequencer directly upstream of the 8-bit universal shift register (iiitb_usr).
//  - Accepts a command (load, shift-left, shift-right or clear, with a repeat count) over a valid/ready handshake.
//  - Drives the register's select, data_in, sl_ser, sr_ser and clear pins for the required cycles.
//  - Captures the register's data_out and returns it on a valid/ready response channel.
// PARAMETERS
//  WIDTH  8  data width; must equal the shift register width
//  CNT_W  4  width of the shift-count field (max 2^CNT_W-1 shifts per command)
// PORTS
//  clock         in   1      rising-edge clock, shared with the shift register
//  clear         in   1      synchronous reset, ACTIVE-LOW
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      command accepted when cmd_valid && cmd_ready
//  cmd_op        in   2      00 SHL, 01 SHR, 10 LOAD, 11 CLR
//  cmd_cnt       in   CNT_W  shift count; ignored for LOAD/CLR
//  cmd_data      in   WIDTH  parallel load value (LOAD only)
//  cmd_ser       in   1      serial fill bit for SHL/SHR
//  cmd_rot       in   1      rotate instead of fill (only with USR_ROTATE_EN)
//  usr_select    out  2      to register select: 00 left, 01 right, 10 load, 11 hold
//  usr_data_in   out  WIDTH  to register data_in
//  usr_sl_ser    out  1      to register sl_ser; enters at LSB on left shift
//  usr_sr_ser    out  1      to register sr_ser; enters at MSB on right shift
//  usr_clear     out  1      to register clear, active-high
//  usr_data_out  in   WIDTH  from register data_out
//  rsp_valid     out  1      response present
//  rsp_ready     in   1      response consumed when rsp_valid && rsp_ready
//  rsp_data      out  WIDTH  register contents after the command
// BEHAVIOUR
//  - FSM states: IDLE, EXEC, SETTLE, RESP. State, remaining count and latched command are registered.
//  - usr_* outputs are decoded combinationally from those registers.
//  - Reset (clear==0 at an edge):
//    - state=IDLE, rsp_valid=0, rsp_data=0, counter=0.
//    - usr_clear=1 while clear is low. cmd_ready=0 while clear is low.
//    - usr_select=11, usr_data_in=0, usr_sl_ser=0, usr_sr_ser=0.
//    - Reset mid-command aborts immediately; no response is issued.
//  - IDLE: cmd_ready=1, usr_select=11.
//    - On handshake, latch op/cnt/data/ser/rot.
//    - Load counter N: cnt for SHL/SHR; 1 for LOAD/CLR.
//    - N==0 goes directly to SETTLE; otherwise goes to EXEC.
//  - EXEC: drive the op for exactly N cycles, decrementing the counter each cycle; cmd_ready=0.
//    - SHL: select=00, sl_ser=ser.
//    - SHR: select=01, sr_ser=ser.
//    - LOAD: select=10, data_in=data.
//    - CLR: usr_clear=1, select=11.
//    - On the last EXEC cycle, go to SETTLE.
//  - SETTLE: one cycle, select=11. rsp_data <= usr_data_out at the closing edge; go to RESP.
//  - RESP: rsp_valid=1; rsp_data is held stable until the handshake, then return to IDLE.
//  - Latency: handshake at cycle 0, EXEC cycles 1..N, SETTLE cycle N+1, rsp_valid from cycle N+2.
//  - Single outstanding command: no new command while EXEC/SETTLE/RESP; no back-to-back overlap.
//  - Outside EXEC, unused usr_data_in and serial lines are driven 0.
// CONFIGURATION
//  - USR_ROTATE_EN defined:
//    - A SHL/SHR command with cmd_rot=1 rotates instead of filling.
//    - SHL: usr_sl_ser = usr_data_out[WIDTH-1].
//    - SHR: usr_sr_ser = usr_data_out[0].
//    - Both are combinational from the live register output each EXEC cycle.
//  - USR_ROTATE_EN undefined:
//    - cmd_rot is ignored, with no rotate logic; the fill bit is always cmd_ser.
// TESTING (WIDTH=8, CNT_W=4)
//  - Reset:
//    - Hold clear=0 for 2 cycles -> usr_clear=1, cmd_ready=0, rsp_valid=0, usr_select=11.
//    - Release -> cmd_ready=1 next cycle.
//  - LOAD cmd_data=8'hAB -> usr_select=10 for 1 cycle; rsp_valid at cycle 3 with rsp_data=8'hAB.
//  - After loading 8'hAB, SHR cnt=3 ser=1 -> 3 cycles of select=01; rsp_data=8'hF5 at cycle 5.
//    SHL cnt=2 ser=0 -> rsp_data=8'hAC.
//  - Count zero and clear:
//    - SHR cnt=0 -> no EXEC cycle; rsp_data equals the current contents at cycle 2.
//    - CLR -> usr_clear pulses 1 cycle; rsp_data=8'h00.
//  - Backpressure:
//    - Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable and cmd_ready=0 throughout.
//    - A pending cmd_valid is not accepted until the cycle after the response handshake.
//  - Rotate (USR_ROTATE_EN): after loading 8'hAB, SHR cnt=1 rot=1 -> 8'hD5; SHL cnt=1 rot=1 on 8'hAB -> 8'h57.
//    Mid-EXEC reset (clear=0 during an SHR of cnt=8) -> IDLE, no rsp_valid, register cleared.

Source files
------------

// File: rtl/iiitb_usr_ctrl.sv
// iiitb_usr_ctrl: command sequencer in front of the iiitb_usr universal shift register.
// Define USR_ROTATE_EN to let SHL/SHR commands rotate instead of using the serial fill bit.
module iiitb_usr_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_ser,
    input  logic             cmd_rot,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_data_in,
    output logic             usr_sl_ser,
    output logic             usr_sr_ser,
    output logic             usr_clear,
    input  logic [WIDTH-1:0] usr_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {
        OP_SHL  = 2'b00,
        OP_SHR  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SETTLE,
        S_RESP
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_next_state;
    op_e              r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_ser;
    logic             w_accept;
    logic             w_single;
    logic             w_fill_sl;
    logic             w_fill_sr;

    assign w_accept = cmd_valid && cmd_ready;
    // LOAD and CLR always run for exactly one EXEC cycle, whatever cmd_cnt says.
    assign w_single = (cmd_op == OP_LOAD) || (cmd_op == OP_CLR);

`ifdef USR_ROTATE_EN
    logic r_rot;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_rot <= 1'b0;
        end else if (w_accept) begin
            r_rot <= cmd_rot;
        end
    end

    assign w_fill_sl = r_rot ? usr_data_out[WIDTH-1] : r_ser;
    assign w_fill_sr = r_rot ? usr_data_out[0] : r_ser;
`else
    logic w_unused_rot;

    assign w_unused_rot = cmd_rot;
    assign w_fill_sl    = r_ser;
    assign w_fill_sr    = r_ser;
`endif

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_op       <= OP_SHL;
            r_cnt      <= '0;
            r_data     <= '0;
            r_ser      <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= op_e'(cmd_op);
                r_cnt  <= w_single ? CNT_ONE : cmd_cnt;
                r_data <= cmd_data;
                r_ser  <= cmd_ser;
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (r_state == S_SETTLE) begin
                r_rsp_data <= usr_data_out;
            end
        end
    end

    // NOTE: every output is given a safe default before the case so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        usr_select   = 2'b11;
        usr_data_in  = '0;
        usr_sl_ser   = 1'b0;
        usr_sr_ser   = 1'b0;
        usr_clear    = !clear;
        if (clear) begin
            case (r_state)
                S_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        w_next_state = (w_single || (cmd_cnt != '0)) ? S_EXEC : S_SETTLE;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        OP_SHL: begin
                            usr_select = 2'b00;
                            usr_sl_ser = w_fill_sl;
                        end
                        OP_SHR: begin
                            usr_select = 2'b01;
                            usr_sr_ser = w_fill_sr;
                        end
                        OP_LOAD: begin
                            usr_select  = 2'b10;
                            usr_data_in = r_data;
                        end
                        default: usr_clear = 1'b1;
                    endcase
                    if (r_cnt == CNT_ONE) begin
                        w_next_state = S_SETTLE;
                    end
                end
                S_SETTLE: w_next_state = S_RESP;
                default: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) begin
                        w_next_state = S_IDLE;
                    end
                end
            endcase
        end
    end

    assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_iiitb_usr_ctrl.sv
// Self-checking bench for iiitb_usr_ctrl: models the downstream shift register and predicts
// each command's result arithmetically; honours USR_ROTATE_EN the same way as the design.
module tb_iiitb_usr_ctrl;

    logic       clock;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [7:0] cmd_data;
    logic       cmd_ser;
    logic       cmd_rot;
    logic [1:0] usr_select;
    logic [7:0] usr_data_in;
    logic       usr_sl_ser;
    logic       usr_sr_ser;
    logic       usr_clear;
    logic [7:0] usr_data_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q    = 8'h00;
    logic [7:0] q;

`ifdef USR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    iiitb_usr_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clock        (clock),
        .clear        (clear),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_cnt      (cmd_cnt),
        .cmd_data     (cmd_data),
        .cmd_ser      (cmd_ser),
        .cmd_rot      (cmd_rot),
        .usr_select   (usr_select),
        .usr_data_in  (usr_data_in),
        .usr_sl_ser   (usr_sl_ser),
        .usr_sr_ser   (usr_sr_ser),
        .usr_clear    (usr_clear),
        .usr_data_out (usr_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream universal shift register driven by the sequencer's pins.
    always @(posedge clock) begin
        if (usr_clear) begin
            q <= 8'h00;
        end else begin
            case (usr_select)
                2'b00:   q <= {q[6:0], usr_sl_ser};
                2'b01:   q <= {usr_sr_ser, q[7:1]};
                2'b10:   q <= usr_data_in;
                default: q <= q;
            endcase
        end
    end
    assign usr_data_out = q;

    function automatic logic [7:0] model(input logic [1:0] op, input int n, input logic [7:0] d,
                                         input logic ser, input logic rot, input logic [7:0] cur);
        logic [31:0] ext;
        logic [15:0] dbl;
        if (op == 2'b10) return d;
        if (op == 2'b11) return 8'h00;
        if (ROT_EN && rot) begin
            dbl = {cur, cur};
            if (op == 2'b00) begin
                dbl = dbl << (n % 8);
                return dbl[15:8];
            end
            dbl = dbl >> (n % 8);
            return dbl[7:0];
        end
        if (op == 2'b00) begin
            ext = {24'h0, cur} << n;
            if (ser) ext = ext | ((32'd1 << n) - 32'd1);
            return ext[7:0];
        end
        ext = ser ? {24'hFFFFFF, cur} : {24'h000000, cur};
        ext = ext >> n;
        return ext[7:0];
    endfunction

    // Starts and ends at a negedge. Issues one command, watches the EXEC window and response.
    task automatic run_cmd(input string name, input logic [1:0] op, input int cnt, input logic [7:0] d,
                           input logic ser, input logic rot, input bit has_exp, input logic [7:0] exp_val,
                           input bit consume);
        int         n;
        int         cyc;
        int         active;
        int         bad;
        logic [1:0] exp_sel;
        logic [7:0] want;
        n       = (op[1]) ? 1 : cnt;
        exp_sel = (op == 2'b11) ? 2'b11 : op;
        want    = has_exp ? exp_val : model(op, cnt, d, ser, rot, exp_q);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready actual=%b required=1", name, cmd_ready);
        end
        cmd_op    = op;
        cmd_cnt   = 4'(cnt);
        cmd_data  = d;
        cmd_ser   = ser;
        cmd_rot   = rot;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        cyc    = 1;
        active = 0;
        bad    = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            if (usr_select !== 2'b11 || usr_clear === 1'b1) begin
                active++;
                if (cyc > n || usr_select !== exp_sel || usr_clear !== (op == 2'b11)) bad++;
            end
            if (cmd_ready !== 1'b0) bad++;
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc != n + 2) begin
            failures++;
            $display("FAIL %s rsp_latency actual=%0d required=%0d", name, cyc, n + 2);
        end
        checks++;
        if (active != n) begin
            failures++;
            $display("FAIL %s exec_cycles actual=%0d required=%0d", name, active, n);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s exec_pins bad_cycles actual=%0d required=0", name, bad);
        end
        checks++;
        if (rsp_data !== want) begin
            failures++;
            $display("FAIL %s rsp_data actual=%h required=%h", name, rsp_data, want);
        end
        exp_q = want;
        if (consume) begin
            rsp_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s after_rsp valid/ready actual=%b/%b required=0/1", name, rsp_valid, cmd_ready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (usr_clear !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || usr_select !== 2'b11) begin
                failures++;
                $display("FAIL reset_pins clr/rdy/vld/sel actual=%b/%b/%b/%b required=1/0/0/11",
                         usr_clear, cmd_ready, rsp_valid, usr_select);
            end
            checks++;
            if (usr_data_in !== 8'h00 || rsp_data !== 8'h00 || usr_sl_ser !== 1'b0 || usr_sr_ser !== 1'b0) begin
                failures++;
                $display("FAIL reset_data din/rsp/sl/sr actual=%h/%h/%b/%b required=00/00/0/0",
                         usr_data_in, rsp_data, usr_sl_ser, usr_sr_ser);
            end
        end
        clear = 1'b1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1 || usr_clear !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL release rdy/clr/vld actual=%b/%b/%b required=1/0/0", cmd_ready, usr_clear, rsp_valid);
        end
        exp_q = 8'h00;
    endtask

    task automatic test_load_shift();
        run_cmd("load_ab", 2'b10, 0, 8'hAB, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        run_cmd("shr3_ser1", 2'b01, 3, 8'h00, 1'b1, 1'b0, 1'b1, 8'hF5, 1'b1);
        run_cmd("load_ab2", 2'b10, 5, 8'hAB, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b1);
        run_cmd("shl2_ser0", 2'b00, 2, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hAC, 1'b1);
    endtask

    task automatic test_zero_clear();
        run_cmd("shr0", 2'b01, 0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAC, 1'b1);
        run_cmd("clr", 2'b11, 9, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        run_cmd("bp_load", 2'b10, 0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        held      = 8'h3C;
        cmd_op    = 2'b00;
        cmd_cnt   = 4'd1;
        cmd_data  = 8'h00;
        cmd_ser   = 1'b1;
        cmd_rot   = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d vld/data/rdy actual=%b/%h/%b required=1/%h/0",
                         i, rsp_valid, rsp_data, cmd_ready, held);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release vld/rdy actual=%b/%b required=0/1", rsp_valid, cmd_ready);
        end
        run_cmd("bp_pending_shl", 2'b00, 1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h79, 1'b1);
    endtask

    task automatic test_rotate();
`ifdef USR_ROTATE_EN
        localparam logic [7:0] EXP_R = 8'hD5;
        localparam logic [7:0] EXP_L = 8'h57;
`else
        localparam logic [7:0] EXP_R = 8'h55;
        localparam logic [7:0] EXP_L = 8'h56;
`endif
        run_cmd("rot_load1", 2'b10, 0, 8'hAB, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        run_cmd("rot_shr1", 2'b01, 1, 8'h00, 1'b0, 1'b1, 1'b1, EXP_R, 1'b1);
        run_cmd("rot_load2", 2'b10, 0, 8'hAB, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        run_cmd("rot_shl1", 2'b00, 1, 8'h00, 1'b0, 1'b1, 1'b1, EXP_L, 1'b1);
    endtask

    task automatic test_mid_reset();
        bit saw_valid;
        run_cmd("mr_load", 2'b10, 0, 8'hAB, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        cmd_op    = 2'b01;
        cmd_cnt   = 4'd8;
        cmd_ser   = 1'b1;
        cmd_rot   = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (usr_clear !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mr_in_reset clr/rdy/vld actual=%b/%b/%b required=1/0/0", usr_clear, cmd_ready, rsp_valid);
        end
        clear     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || cmd_ready !== 1'b1 || usr_select !== 2'b11) begin
            failures++;
            $display("FAIL mr_abort saw_vld/rdy/sel actual=%b/%b/%b required=0/1/11", saw_valid, cmd_ready, usr_select);
        end
        checks++;
        if (q !== 8'h00 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL mr_cleared reg/rsp actual=%h/%h required=00/00", q, rsp_data);
        end
        exp_q = 8'h00;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_cmd("random", 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b1);
        end
    endtask

    initial begin
        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = 4'd0;
        cmd_data  = 8'h00;
        cmd_ser   = 1'b0;
        cmd_rot   = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_load_shift();
        test_zero_clear();
        test_backpressure();
        test_rotate();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
